// File: rtl/axi_rom_arbiter.sv
// Round-robin arbiter sharing one boot ROM among NUM_REQ AXI read ports.
// Define ROM_ARB_RANGE_CHK_EN to return SLVERR for word addresses >= ROM_DEPTH.
module axi_rom_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ROM_DEPTH = 16384,
  parameter int ID_W      = 4
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [NUM_REQ-1:0]      ar_valid,
  output logic [NUM_REQ-1:0]      ar_ready,
  input  logic [NUM_REQ*16-1:0]   ar_addr,
  input  logic [NUM_REQ*8-1:0]    ar_len,
  input  logic [NUM_REQ*ID_W-1:0] ar_id,
  output logic [NUM_REQ-1:0]      r_valid,
  input  logic [NUM_REQ-1:0]      r_ready,
  output logic [31:0]             r_data,
  output logic [ID_W-1:0]         r_id,
  output logic [1:0]              r_resp,
  output logic                    r_last,
  output logic                    rom_en,
  output logic [13:0]             rom_addr,
  input  logic [31:0]             rom_data
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] ONE = NUM_REQ'(1);

  typedef enum logic [1:0] {IDLE, FETCH, RESP} state_t;

  state_t          state;
  logic [GW-1:0]   last_grant;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   sel;
  logic            sel_ok;
  logic [13:0]     waddr;
  logic [7:0]      len;
  logic [7:0]      beat;
  logic [ID_W-1:0] id;
  logic            ar_hs;
  logic            r_hs;
  logic            resp_st;
  int              c;

  logic [13:0]     req_waddr [NUM_REQ];
  logic [7:0]      req_len   [NUM_REQ];
  logic [ID_W-1:0] req_id    [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_req
    assign req_waddr[k] = ar_addr[16*k+2 +: 14];
    assign req_len[k]   = ar_len[8*k +: 8];
    assign req_id[k]    = ar_id[ID_W*k +: ID_W];
  end

  // Search starts just past the last winner so every port gets a turn.
  always_comb begin
    sel    = '0;
    sel_ok = 1'b0;
    c      = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = int'(last_grant) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      if (!sel_ok && ar_valid[GW'(c)]) begin
        sel    = GW'(c);
        sel_ok = 1'b1;
      end
    end
  end

  assign resp_st = (state == RESP);
  assign ar_ready = (state == IDLE && sel_ok && !arst)
                    ? (ONE << sel) : '0;
  assign ar_hs    = |(ar_valid & ar_ready);
  assign r_hs     = resp_st && r_ready[grant];
  assign r_valid  = (resp_st && !arst) ? (ONE << grant) : '0;
  assign r_last   = resp_st && (beat == len);
  assign r_id     = id;
  assign rom_en   = (state != IDLE) && !arst;
  assign rom_addr = waddr;

`ifdef ROM_ARB_RANGE_CHK_EN
  logic oob;
  assign oob    = 32'(waddr) >= 32'(ROM_DEPTH);
  assign r_data = (resp_st && !oob) ? rom_data : '0;
  assign r_resp = (resp_st && oob) ? 2'b10 : 2'b00;
`else
  assign r_data = resp_st ? rom_data : '0;
  assign r_resp = 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (arst) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      grant      <= '0;
      waddr      <= '0;
      len        <= '0;
      beat       <= '0;
      id         <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ar_hs) begin
            waddr      <= req_waddr[sel];
            len        <= req_len[sel];
            id         <= req_id[sel];
            grant      <= sel;
            last_grant <= sel;
            beat       <= '0;
            state      <= FETCH;
          end
        end
        FETCH: state <= RESP;
        RESP: begin
          if (r_hs) begin
            if (r_last) begin
              state <= IDLE;
            end else begin
              waddr <= waddr + 14'd1;
              beat  <= beat + 8'd1;
              state <= FETCH;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rom_arbiter.sv
// Randomized bench for axi_rom_arbiter against a beat-queue reference model.
// The model expands each granted burst into timed beats and checks every cycle.
module tb_axi_rom_arbiter;

  localparam int N     = 2;
  localparam int ID_W  = 4;
  localparam int DEPTH = 16384;

  logic              clk = 1'b0;
  logic              arst;
  logic [N-1:0]      ar_valid, ar_ready, r_valid, r_ready;
  logic [N*16-1:0]   ar_addr;
  logic [N*8-1:0]    ar_len;
  logic [N*ID_W-1:0] ar_id;
  logic [31:0]       r_data, rom_data;
  logic [ID_W-1:0]   r_id;
  logic [1:0]        r_resp;
  logic              r_last, rom_en;
  logic [13:0]       rom_addr;

  axi_rom_arbiter #(.NUM_REQ(N), .ROM_DEPTH(DEPTH), .ID_W(ID_W)) dut (
    .clk(clk), .arst(arst),
    .ar_valid(ar_valid), .ar_ready(ar_ready),
    .ar_addr(ar_addr), .ar_len(ar_len), .ar_id(ar_id),
    .r_valid(r_valid), .r_ready(r_ready),
    .r_data(r_data), .r_id(r_id), .r_resp(r_resp), .r_last(r_last),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] romf(logic [13:0] a);
    return {2'b10, a, 2'b01, ~a};
  endfunction

  always @(posedge clk) if (rom_en) rom_data <= romf(rom_addr);

  typedef struct {
    int              req;
    logic [13:0]     word;
    logic [ID_W-1:0] id;
    logic            last;
  } beat_t;

  beat_t q[$];
  int    gq[$];
  int    lg, beat_at, cyc;
  int    n_chk = 0, n_bad = 0;

  logic              nx_arst;
  logic [N-1:0]      nx_valid, nx_rready;
  logic [N*16-1:0]   nx_addr;
  logic [N*8-1:0]    nx_len;
  logic [N*ID_W-1:0] nx_id;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int pick(logic [N-1:0] v);
    for (int i = 1; i <= N; i++) begin
      if (v[(lg + i) % N]) return (lg + i) % N;
    end
    return -1;
  endfunction

  task automatic set_req(int k, logic [15:0] a, logic [7:0] l,
                         logic [ID_W-1:0] i);
    nx_addr[16*k +: 16]  = a;
    nx_len[8*k +: 8]     = l;
    nx_id[ID_W*k +: ID_W] = i;
  endtask

  task automatic cycle();
    logic [N-1:0] e_ar, e_rv;
    logic         e_en, oob;
    logic [13:0]  w;
    int           p, ln;
    @(negedge clk);
    arst = nx_arst;  ar_valid = nx_valid; ar_addr = nx_addr;
    ar_len = nx_len; ar_id = nx_id;       r_ready = nx_rready;
    #1;
    e_ar = '0; e_rv = '0; e_en = 1'b0;
    p = pick(ar_valid);
    if (!arst) begin
      if (q.size() == 0) begin
        if (p >= 0) e_ar = N'(1) << p;
      end else begin
        e_en = 1'b1;
        chk("rom_addr", 64'(rom_addr), 64'(q[0].word));
        if (cyc >= beat_at) begin
          e_rv = N'(1) << q[0].req;
          oob = 1'b0;
`ifdef ROM_ARB_RANGE_CHK_EN
          oob = int'(q[0].word) >= DEPTH;
`endif
          chk("r_data", 64'(r_data), oob ? 64'd0 : 64'(romf(q[0].word)));
          chk("r_resp", 64'(r_resp), oob ? 64'd2 : 64'd0);
          chk("r_id", 64'(r_id), 64'(q[0].id));
          chk("r_last", 64'(r_last), 64'(q[0].last));
        end
      end
    end
    chk("ar_ready", 64'(ar_ready), 64'(e_ar));
    chk("r_valid", 64'(r_valid), 64'(e_rv));
    chk("rom_en", 64'(rom_en), 64'(e_en));
    for (int k = 0; k < N; k++)
      if (ar_valid[k] && ar_ready[k]) gq.push_back(k);
    if (arst) begin
      q.delete();
      lg = N - 1;
    end else if (q.size() == 0) begin
      if (p >= 0) begin
        w  = ar_addr[16*p+2 +: 14];
        ln = int'(ar_len[8*p +: 8]);
        for (int b = 0; b <= ln; b++)
          q.push_back('{p, w + 14'(b), ar_id[ID_W*p +: ID_W], b == ln});
        lg = p;
        beat_at = cyc + 2;
      end
    end else if (cyc >= beat_at && r_ready[q[0].req]) begin
      void'(q.pop_front());
      beat_at = cyc + 2;
    end
    cyc++;
  endtask

  task automatic do_reset();
    nx_arst = 1'b1; nx_valid = '0;
    repeat (2) cycle();
    nx_arst = 1'b0;
    cycle();
    chk("rst_r_data", 64'(r_data), 64'd0);
    chk("rst_r_last", 64'(r_last), 64'd0);
    chk("rst_r_resp", 64'(r_resp), 64'd0);
    chk("rst_rom_addr", 64'(rom_addr), 64'd0);
  endtask

  initial begin
    arst = 1'b1; ar_valid = '0; r_ready = '0;
    ar_addr = '0; ar_len = '0; ar_id = '0;
    nx_arst = 1'b1; nx_valid = '0; nx_rready = '0;
    nx_addr = '0; nx_len = '0; nx_id = '0;
    lg = N - 1; beat_at = 0; cyc = 0;
    do_reset();

    set_req(0, 16'h0010, 8'd0, 4'h3);
    nx_valid = 2'b01; nx_rready = '1;
    cycle();
    nx_valid = '0;
    repeat (4) cycle();

    set_req(1, 16'h0100, 8'd3, 4'h9);
    nx_valid = 2'b10;
    cycle();
    nx_valid = '0;
    for (int i = 0; i < 30; i++) begin
      nx_rready = (i % 3 == 0) ? 2'b10 : 2'b01;
      cycle();
    end

    set_req(0, 16'hFFFC, 8'd1, 4'h5);
    nx_valid = 2'b01; nx_rready = '1;
    cycle();
    nx_valid = '0;
    repeat (8) cycle();

    do_reset();
    gq.delete();
    set_req(0, 16'h0020, 8'd0, 4'h1);
    set_req(1, 16'h0040, 8'd0, 4'h2);
    nx_valid = 2'b11; nx_rready = '1;
    repeat (14) cycle();
    nx_valid = '0;
    repeat (3) cycle();
    chk("grant_count", 64'(gq.size() >= 4), 64'd1);
    if (gq.size() >= 4) begin
      chk("grant0", 64'(gq[0]), 64'd0);
      chk("grant1", 64'(gq[1]), 64'd1);
      chk("grant2", 64'(gq[2]), 64'd0);
      chk("grant3", 64'(gq[3]), 64'd1);
    end

    set_req(1, 16'h1234, 8'd7, 4'hA);
    nx_valid = 2'b10; nx_rready = '1;
    cycle();
    nx_valid = '0;
    for (int i = 0; i < 40 && q.size() > 6; i++) cycle();
    chk("mid_burst_reached", 64'(q.size()), 64'd6);
    do_reset();
    gq.delete();
    nx_valid = 2'b11;
    cycle();
    nx_valid = '0;
    chk("post_rst_grant_seen", 64'(gq.size()), 64'd1);
    if (gq.size() >= 1) chk("post_rst_grant", 64'(gq[0]), 64'd0);
    repeat (4) cycle();

    for (int i = 0; i < 5000; i++) begin
      nx_arst  = ($urandom_range(0, 699) == 0);
      nx_valid = N'($urandom);
      for (int k = 0; k < N; k++)
        set_req(k,
                ($urandom_range(0, 9) == 0) ? (16'hFFF0 | 16'($urandom_range(0, 15)))
                                            : 16'($urandom),
                ($urandom_range(0, 79) == 0) ? 8'd255 : 8'($urandom_range(0, 4)),
                ID_W'($urandom));
      nx_rready = N'($urandom);
      cycle();
    end

    nx_arst = 1'b0; nx_valid = '0; nx_rready = '1;
    for (int i = 0; i < 600 && q.size() > 0; i++) cycle();
    chk("drain", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
